// File: rtl/codificador_pkg.sv
// Shared definitions for the sequential 4-to-2 encoder: line count, default
// lost-counter width and the handshake state type.
package codificador_pkg;
  localparam int N_LINEAS           = 4;
  localparam int ANCHO_PERDIDAS_DEF = 8;

  typedef enum logic {
    INACTIVO    = 1'b0,
    PRESENTANDO = 1'b1
  } estado_t;
endpackage

// File: rtl/codificador_4a2_secuencial_detector_flancos.sv
// N-bit rising-edge detector: registers the previous line levels and flags
// every line that is high now but was low on the previous edge.
module detector_flancos #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] flanco
);

  logic [N-1:0] prev_r;

  // Line history; cleared on reset so lines already high count as new events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_r <= {N{1'b0}};
    end else begin
      prev_r <= d;
    end
  end

  assign flanco = d & ~prev_r;

endmodule

// File: rtl/codificador_4a2_secuencial.sv
// Registered 4-to-2 encoder: captures request edges as pending events,
// arbitrates them and presents one code at a time under a valid/ack handshake.
module codificador_4a2_secuencial
  import codificador_pkg::*;
#(
  parameter bit MODO_RR        = 1'b0,
  parameter int ANCHO_PERDIDAS = ANCHO_PERDIDAS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      d0,
  input  logic                      d1,
  input  logic                      d2,
  input  logic                      d3,
  input  logic                      ack,
  output logic                      a0,
  output logic                      a1,
  output logic                      valido,
  output logic [N_LINEAS-1:0]       pendientes,
  output logic [ANCHO_PERDIDAS-1:0] perdidas
);

  localparam logic [ANCHO_PERDIDAS-1:0] PERD_MAX = {ANCHO_PERDIDAS{1'b1}};

  // Fixed priority: the highest pending index wins.
  function automatic logic [1:0] arb_fija(input logic [N_LINEAS-1:0] p);
    logic [1:0] g;
    g = 2'd0;
    for (int i = 0; i < N_LINEAS; i++) begin
      if (p[i]) begin
        g = i[1:0];
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

  // Round-robin: first pending index found scanning upward after the last grant.
  function automatic logic [1:0] arb_rr(input logic [N_LINEAS-1:0] p,
                                        input logic [1:0]          ultimo);
    logic [1:0] g;
    logic [1:0] idx;
    logic       hallado;
    g       = 2'd0;
    hallado = 1'b0;
    for (int k = 1; k <= N_LINEAS; k++) begin
      idx = ultimo + k[1:0];
      if (!hallado && p[idx]) begin
        g       = idx;
        hallado = 1'b1;
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

  estado_t                   estado_r, estado_s;
  logic [1:0]                codigo_r, codigo_s;
  logic                      valido_r, valido_s;
  logic [N_LINEAS-1:0]       pend_r, pend_s;
  logic [ANCHO_PERDIDAS-1:0] perd_r, perd_s;
  logic [1:0]                ultimo_r, ultimo_s;
  logic [N_LINEAS-1:0]       flanco_s;
  logic [N_LINEAS-1:0]       borrar_s;
  logic [1:0]                indice_s;
  logic                      hay_s;
  logic                      conceder_s;
  logic                      perdido_s;

  detector_flancos #(.N(N_LINEAS)) u_detector (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      ({d3, d2, d1, d0}),
    .flanco (flanco_s)
  );

  // Next-state, grant and pending/lost-counter logic.
  always_comb begin
    estado_s   = estado_r;
    codigo_s   = codigo_r;
    valido_s   = valido_r;
    conceder_s = 1'b0;
    indice_s   = MODO_RR ? arb_rr(pend_r, ultimo_r) : arb_fija(pend_r);
    hay_s      = en && (pend_r != {N_LINEAS{1'b0}});

    case (estado_r)
      INACTIVO: begin
        if (hay_s) begin
          conceder_s = 1'b1;
          estado_s   = PRESENTANDO;
        end else begin
          estado_s = INACTIVO;
        end
      end
      PRESENTANDO: begin
        if (ack) begin
          if (hay_s) begin
            conceder_s = 1'b1;
          end else begin
            valido_s = 1'b0;
            estado_s = INACTIVO;
          end
        end else begin
          estado_s = PRESENTANDO;
        end
      end
      default: begin
        valido_s = 1'b0;
        estado_s = INACTIVO;
      end
    endcase

    if (conceder_s) begin
      codigo_s = indice_s;
      valido_s = 1'b1;
      borrar_s = 4'b0001 << indice_s;
      ultimo_s = indice_s;
    end else begin
      borrar_s = {N_LINEAS{1'b0}};
      ultimo_s = ultimo_r;
    end

    // An edge on a line that is still pending and not being granted now is lost.
    pend_s    = (pend_r & ~borrar_s) | flanco_s;
    perdido_s = |(flanco_s & pend_r & ~borrar_s);
    if (perdido_s && (perd_r != PERD_MAX)) begin
      perd_s = perd_r + ANCHO_PERDIDAS'(1);
    end else begin
      perd_s = perd_r;
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_r <= INACTIVO;
      codigo_r <= 2'd0;
      valido_r <= 1'b0;
      pend_r   <= {N_LINEAS{1'b0}};
      perd_r   <= {ANCHO_PERDIDAS{1'b0}};
      ultimo_r <= 2'd3;
    end else begin
      estado_r <= estado_s;
      codigo_r <= codigo_s;
      valido_r <= valido_s;
      pend_r   <= pend_s;
      perd_r   <= perd_s;
      ultimo_r <= ultimo_s;
    end
  end

  assign a0         = codigo_r[0];
  assign a1         = codigo_r[1];
  assign valido     = valido_r;
  assign pendientes = pend_r;
  assign perdidas   = perd_r;

endmodule

// File: tb/tb_codificador_4a2_secuencial.sv
// Directed bench: fixed-priority, round-robin and narrow-counter instances
// share the stimulus; a cycle table plus hand sequences check each one.
module tb_codificador_4a2_secuencial;

  logic clk = 1'b0;
  logic rst_n, en, d0, d1, d2, d3, ack;

  logic       a0_fp, a1_fp, valido_fp;
  logic [3:0] pend_fp;
  logic [7:0] perd_fp;
  logic       a0_rr, a1_rr, valido_rr;
  logic [3:0] pend_rr;
  logic [7:0] perd_rr;
  logic       a0_sat, a1_sat, valido_sat;
  logic [3:0] pend_sat;
  logic [1:0] perd_sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  codificador_4a2_secuencial #(.MODO_RR(1'b0), .ANCHO_PERDIDAS(8)) dut_fp (
    .clk(clk), .rst_n(rst_n), .en(en), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .ack(ack), .a0(a0_fp), .a1(a1_fp), .valido(valido_fp),
    .pendientes(pend_fp), .perdidas(perd_fp));

  codificador_4a2_secuencial #(.MODO_RR(1'b1), .ANCHO_PERDIDAS(8)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .ack(ack), .a0(a0_rr), .a1(a1_rr), .valido(valido_rr),
    .pendientes(pend_rr), .perdidas(perd_rr));

  codificador_4a2_secuencial #(.MODO_RR(1'b0), .ANCHO_PERDIDAS(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .ack(ack), .a0(a0_sat), .a1(a1_sat), .valido(valido_sat),
    .pendientes(pend_sat), .perdidas(perd_sat));

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] d;
    logic       ack;
    logic       rr;
    logic       exp_valido;
    logic [1:0] exp_codigo;
    logic [3:0] exp_pend;
    int         exp_perd;
  } vec_t;

  vec_t tabla [18];

  task automatic comparar(input string nombre, input int actual, input int esperado);
    checks++;
    if (actual != esperado) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nombre, actual, esperado);
    end
  endtask

  // Apply inputs, then return 1 time unit after the next rising edge.
  task automatic paso(input logic r, input logic e, input logic [3:0] dd, input logic k);
    rst_n = r;
    en    = e;
    {d3, d2, d1, d0} = dd;
    ack   = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       v;
    logic [1:0] c;
    logic [3:0] p;
    int         q;

    //                rst   en    d        ack   rr    val   code  pend     perd
    tabla[0]  = '{1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 0};
    tabla[1]  = '{1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 0};
    tabla[2]  = '{1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 0};
    tabla[3]  = '{1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 0};
    tabla[4]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 0};
    tabla[5]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 0};
    tabla[6]  = '{1'b1, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1001, 0};
    tabla[7]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0001, 0};
    tabla[8]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 0};
    tabla[9]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 0};
    tabla[10] = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 0};
    tabla[11] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 0};
    tabla[12] = '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1111, 0};
    tabla[13] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1110, 0};
    tabla[14] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 4'b1100, 0};
    tabla[15] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1000, 0};
    tabla[16] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 0};
    tabla[17] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 0};

    rst_n = 1'b0; en = 1'b0; {d3, d2, d1, d0} = 4'b0000; ack = 1'b0;

    for (int i = 0; i < 18; i++) begin
      paso(tabla[i].rst_n, tabla[i].en, tabla[i].d, tabla[i].ack);
      if (tabla[i].rr) begin
        v = valido_rr; c = {a1_rr, a0_rr}; p = pend_rr; q = int'(perd_rr);
      end else begin
        v = valido_fp; c = {a1_fp, a0_fp}; p = pend_fp; q = int'(perd_fp);
      end
      comparar($sformatf("vec%0d_valido", i), int'(v), int'(tabla[i].exp_valido));
      if (tabla[i].exp_valido) begin
        comparar($sformatf("vec%0d_codigo", i), int'(c), int'(tabla[i].exp_codigo));
      end
      comparar($sformatf("vec%0d_pend", i), int'(p), int'(tabla[i].exp_pend));
      comparar($sformatf("vec%0d_perd", i), q, tabla[i].exp_perd);
    end

    // Second edge on a still-pending line while en is low: one loss, one code.
    paso(1'b0, 1'b0, 4'b0000, 1'b0);
    paso(1'b1, 1'b0, 4'b0010, 1'b0);
    paso(1'b1, 1'b0, 4'b0000, 1'b0);
    paso(1'b1, 1'b0, 4'b0010, 1'b0);
    paso(1'b1, 1'b0, 4'b0000, 1'b0);
    comparar("perdido_pend", int'(pend_fp), 2);
    comparar("perdido_perd", int'(perd_fp), 1);
    comparar("perdido_valido0", int'(valido_fp), 0);
    paso(1'b1, 1'b1, 4'b0000, 1'b1);
    comparar("perdido_valido1", int'(valido_fp), 1);
    comparar("perdido_codigo", int'({a1_fp, a0_fp}), 1);
    comparar("perdido_pend_vacio", int'(pend_fp), 0);
    paso(1'b1, 1'b1, 4'b0000, 1'b1);
    comparar("perdido_fin", int'(valido_fp), 0);
    paso(1'b1, 1'b1, 4'b0000, 1'b1);
    comparar("perdido_sin_repeticion", int'(valido_fp), 0);

    // Re-pulse on the granting edge: set beats clear, no loss, code repeats.
    paso(1'b0, 1'b0, 4'b0000, 1'b0);
    paso(1'b1, 1'b0, 4'b0010, 1'b0);
    paso(1'b1, 1'b0, 4'b0000, 1'b0);
    paso(1'b1, 1'b1, 4'b0010, 1'b0);
    comparar("rearme_valido", int'(valido_fp), 1);
    comparar("rearme_codigo", int'({a1_fp, a0_fp}), 1);
    comparar("rearme_pend", int'(pend_fp), 2);
    comparar("rearme_perd", int'(perd_fp), 0);
    paso(1'b1, 1'b1, 4'b0000, 1'b1);
    comparar("rearme_valido2", int'(valido_fp), 1);
    comparar("rearme_codigo2", int'({a1_fp, a0_fp}), 1);
    comparar("rearme_pend2", int'(pend_fp), 0);
    paso(1'b1, 1'b1, 4'b0000, 1'b1);
    comparar("rearme_fin", int'(valido_fp), 0);
    comparar("rearme_perd_fin", int'(perd_fp), 0);

    // Reset while presenting with lines 1 and 3 pending.
    paso(1'b0, 1'b0, 4'b0000, 1'b0);
    paso(1'b1, 1'b1, 4'b0100, 1'b0);
    paso(1'b1, 1'b1, 4'b0000, 1'b0);
    paso(1'b1, 1'b1, 4'b1010, 1'b0);
    comparar("prereset_valido", int'(valido_fp), 1);
    comparar("prereset_codigo", int'({a1_fp, a0_fp}), 2);
    comparar("prereset_pend", int'(pend_fp), 10);
    paso(1'b0, 1'b1, 4'b0000, 1'b1);
    comparar("reset_valido", int'(valido_fp), 0);
    comparar("reset_codigo", int'({a1_fp, a0_fp}), 0);
    comparar("reset_pend", int'(pend_fp), 0);
    comparar("reset_perd", int'(perd_fp), 0);
    paso(1'b1, 1'b1, 4'b0000, 1'b1);
    comparar("postreset_ack_valido", int'(valido_fp), 0);
    comparar("postreset_ack_pend", int'(pend_fp), 0);

    // Five lost events: 8-bit counter reaches 5, 2-bit counter sticks at 3.
    paso(1'b0, 1'b0, 4'b0000, 1'b0);
    paso(1'b1, 1'b0, 4'b0010, 1'b0);
    paso(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int n = 0; n < 5; n++) begin
      paso(1'b1, 1'b0, 4'b0010, 1'b0);
      paso(1'b1, 1'b0, 4'b0000, 1'b0);
    end
    comparar("sat_perd_ancho8", int'(perd_fp), 5);
    comparar("sat_perd_ancho2", int'(perd_sat), 3);
    comparar("sat_pend", int'(pend_sat), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
